// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, operator and entry-state
// encodings, BCD digit width.
package calc_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_ENTER_A = 2'b00,
        ST_ENTER_B = 2'b01,
        ST_ISSUE   = 2'b10,
        ST_WAIT    = 2'b11
    } entry_state_t;

    function automatic logic is_op_key(input logic [3:0] k);
        return (k == KEY_ADD) || (k == KEY_SUB) ||
               (k == KEY_MUL) || (k == KEY_DIV);
    endfunction

    function automatic op_t key_to_op(input logic [3:0] k);
        logic [3:0] d;
        d = k - KEY_ADD;
        return op_t'(d[1:0]);
    endfunction

endpackage

// File: rtl/operand_entry_if.sv
// Keypad, ALU and display signals of operand_entry.
// master drives keys/ALU status; slave is the entry block.
interface operand_entry_if #(parameter int DIGITS = 4);

    logic                  key_valid;
    logic                  keytype;
    logic [3:0]            key;
    logic                  alu_busy;
    logic                  result_valid;
    logic [4*DIGITS-1:0]   result;
    logic [4*DIGITS-1:0]   operand_a;
    logic [4*DIGITS-1:0]   operand_b;
    logic [1:0]            operator;
    logic                  start;
    logic [4*DIGITS-1:0]   display;
    logic                  overflow;
    logic [1:0]            entry_state;

    modport master (
        output key_valid, keytype, key, alu_busy, result_valid, result,
        input  operand_a, operand_b, operator, start, display,
        input  overflow, entry_state
    );

    modport slave (
        input  key_valid, keytype, key, alu_busy, result_valid, result,
        output operand_a, operand_b, operator, start, display,
        output overflow, entry_state
    );

endinterface

// File: rtl/bcd_shift_reg.sv
// One BCD operand register with digit count; zero/load/insert controls.
// zero together with insert restarts the operand with the new digit.
module bcd_shift_reg
    import calc_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      insert,
    input  logic                      zero,
    input  logic                      load,
    input  logic [DIGIT_W-1:0]        digit,
    input  logic [DIGIT_W*DIGITS-1:0] load_value,
    output logic [DIGIT_W*DIGITS-1:0] value,
    output logic [$clog2(DIGITS+1)-1:0] count,
    output logic                      full
);

    localparam int W  = DIGIT_W * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    logic [W-1:0]  base_v;
    logic [CW-1:0] base_c;
    logic          take;

    always_comb begin
        base_v = zero ? '0 : value;
        base_c = zero ? '0 : count;
        // A leading zero never occupies a digit slot
        take   = (base_c < CW'(DIGITS)) &&
                 !((base_c == '0) && (digit == '0));
    end

    assign full = (count == CW'(DIGITS));

    always_ff @(posedge clock) begin
        if (reset) begin
            value <= '0;
            count <= '0;
        end else if (load) begin
            value <= load_value;
            count <= CW'(DIGITS);
        end else if (insert && take) begin
            value <= (base_v << DIGIT_W) | W'(digit);
            count <= base_c + 1'b1;
        end else begin
            value <= base_v;
            count <= base_c;
        end
    end

endmodule

// File: rtl/operand_entry.sv
// Calculator operand entry: builds BCD operands from keys, issues ALU start.
// Define OPERAND_ENTRY_CHAIN_EN to load the ALU result back into operand A.
module operand_entry
    import calc_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic           clock,
    input  logic           reset,
    operand_entry_if.slave bus
);

    localparam int W  = DIGIT_W * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

`ifdef OPERAND_ENTRY_CHAIN_EN
    localparam logic CHAIN = 1'b1;
`else
    localparam logic CHAIN = 1'b0;
`endif

    entry_state_t  state;
    op_t           operator_q;
    logic          start_q, overflow_q, fresh;
    logic [W-1:0]  a_val, b_val;
    logic [CW-1:0] a_cnt, b_cnt;
    logic          a_full, b_full;
    logic          dig, fn, op_key, eq_key, clr, res;
    logic          in_a, in_b, b_empty;
    logic          a_ins, a_zero, a_load, b_ins, b_zero;
    logic          a_ovf, b_ovf;

    always_comb begin
        dig     = bus.key_valid & bus.keytype;
        fn      = bus.key_valid & ~bus.keytype;
        op_key  = fn & is_op_key(bus.key);
        eq_key  = fn & (bus.key == KEY_EQ);
        clr     = fn & (bus.key == KEY_CLR) & (state != ST_WAIT);
        res     = bus.result_valid & (state == ST_WAIT);
        in_a    = (state == ST_ENTER_A);
        in_b    = (state == ST_ENTER_B);
        b_empty = (b_cnt == '0);
        a_ins   = dig & in_a;
        a_zero  = clr | (res & ~CHAIN) | (a_ins & fresh);
        a_load  = res & CHAIN;
        b_ins   = dig & in_b;
        b_zero  = clr | (op_key & in_a) | res;
        // A digit after a chained result restarts A, so it cannot overflow
        a_ovf   = a_ins & a_full & ~fresh;
        b_ovf   = b_ins & b_full;
    end

    bcd_shift_reg #(.DIGITS(DIGITS)) u_a (
        .clock      (clock),
        .reset      (reset),
        .insert     (a_ins),
        .zero       (a_zero),
        .load       (a_load),
        .digit      (bus.key),
        .load_value (bus.result),
        .value      (a_val),
        .count      (a_cnt),
        .full       (a_full)
    );

    bcd_shift_reg #(.DIGITS(DIGITS)) u_b (
        .clock      (clock),
        .reset      (reset),
        .insert     (b_ins),
        .zero       (b_zero),
        .load       (1'b0),
        .digit      (bus.key),
        .load_value (bus.result),
        .value      (b_val),
        .count      (b_cnt),
        .full       (b_full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_ENTER_A;
            operator_q <= OP_ADD;
            start_q    <= 1'b0;
            overflow_q <= 1'b0;
            fresh      <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (a_ovf || b_ovf) overflow_q <= 1'b1;
            unique case (state)
                ST_ENTER_A: begin
                    if (clr) begin
                        operator_q <= OP_ADD;
                        overflow_q <= 1'b0;
                        fresh      <= 1'b0;
                    end else if (op_key) begin
                        operator_q <= key_to_op(bus.key);
                        state      <= ST_ENTER_B;
                        fresh      <= 1'b0;
                    end else if (dig) begin
                        fresh <= 1'b0;
                    end
                end
                ST_ENTER_B: begin
                    if (clr) begin
                        operator_q <= OP_ADD;
                        overflow_q <= 1'b0;
                        fresh      <= 1'b0;
                        state      <= ST_ENTER_A;
                    end else if (op_key && b_empty) begin
                        operator_q <= key_to_op(bus.key);
                    end else if (eq_key && !b_empty) begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (clr) begin
                        operator_q <= OP_ADD;
                        overflow_q <= 1'b0;
                        fresh      <= 1'b0;
                        state      <= ST_ENTER_A;
                    end else if (!bus.alu_busy) begin
                        start_q <= 1'b1;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (res) begin
                        operator_q <= OP_ADD;
                        fresh      <= CHAIN;
                        state      <= ST_ENTER_A;
                    end
                end
            endcase
        end
    end

    always_comb begin
        unique case (state)
            ST_ENTER_A: bus.display = a_val;
            ST_ENTER_B: bus.display = b_empty ? a_val : b_val;
            default:    bus.display = b_val;
        endcase
    end

    assign bus.operand_a   = a_val;
    assign bus.operand_b   = b_val;
    assign bus.operator    = operator_q;
    assign bus.start       = start_q;
    assign bus.overflow    = overflow_q;
    assign bus.entry_state = state;

endmodule

// File: tb/tb_operand_entry.sv
// Directed test of operand_entry with DIGITS=4.
// Expected values follow OPERAND_ENTRY_CHAIN_EN when it is defined.
module tb_operand_entry;
    import calc_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;

`ifdef OPERAND_ENTRY_CHAIN_EN
    localparam logic [15:0] EXP_A_RES = 16'h0099;
`else
    localparam logic [15:0] EXP_A_RES = 16'h0000;
`endif

    always #5 clock = ~clock;

    operand_entry_if #(.DIGITS(4)) bus ();

    operand_entry #(.DIGITS(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic kt, input logic [3:0] k);
        bus.key_valid = 1'b1;
        bus.keytype   = kt;
        bus.key       = k;
        tick();
        bus.key_valid = 1'b0;
        bus.keytype   = 1'b0;
        bus.key       = 4'h0;
    endtask

    task automatic digit(input logic [3:0] k);
        press(1'b1, k);
    endtask

    task automatic fkey(input logic [3:0] k);
        press(1'b0, k);
    endtask

    task automatic give_result(input logic [15:0] r);
        bus.result_valid = 1'b1;
        bus.result       = r;
        tick();
        bus.result_valid = 1'b0;
    endtask

    initial begin
        bus.key_valid    = 1'b0;
        bus.keytype      = 1'b0;
        bus.key          = 4'h0;
        bus.alu_busy     = 1'b0;
        bus.result_valid = 1'b0;
        bus.result       = 16'h0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_a", bus.operand_a, 0);
        chk("rst_b", bus.operand_b, 0);
        chk("rst_op", bus.operator, 0);
        chk("rst_start", bus.start, 0);
        chk("rst_disp", bus.display, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_state", bus.entry_state, 0);

        // 1 2 A 3 E
        digit(4'd1);
        digit(4'd2);
        chk("add_a", bus.operand_a, 32'h12);
        chk("add_disp_a", bus.display, 32'h12);
        fkey(KEY_ADD);
        chk("add_state_b", bus.entry_state, 1);
        chk("add_op", bus.operator, 0);
        chk("add_disp_b0", bus.display, 32'h12);
        digit(4'd3);
        chk("add_b", bus.operand_b, 32'h3);
        chk("add_disp_b", bus.display, 32'h3);
        fkey(KEY_EQ);
        chk("add_issue", bus.entry_state, 2);
        chk("add_start_n", bus.start, 0);
        tick();
        chk("add_start", bus.start, 1);
        chk("add_wait", bus.entry_state, 3);
        tick();
        chk("add_start_1cyc", bus.start, 0);
        chk("add_wait_a", bus.operand_a, 32'h12);
        chk("add_wait_disp", bus.display, 32'h3);

        give_result(16'h0099);
        chk("res_state", bus.entry_state, 0);
        chk("res_a", bus.operand_a, {16'h0, EXP_A_RES});
        chk("res_b", bus.operand_b, 0);
        chk("res_op", bus.operator, 0);
        digit(4'd5);
        chk("res_fresh_a", bus.operand_a, 32'h5);
        fkey(KEY_CLR);
        chk("clr_a", bus.operand_a, 0);

        // 0 0 1 2 3 4 5
        digit(4'd0);
        digit(4'd0);
        chk("lz_a", bus.operand_a, 0);
        digit(4'd1);
        digit(4'd2);
        digit(4'd3);
        digit(4'd4);
        chk("full_a", bus.operand_a, 32'h1234);
        chk("full_ovf", bus.overflow, 0);
        digit(4'd5);
        chk("ovf_a", bus.operand_a, 32'h1234);
        chk("ovf_set", bus.overflow, 1);
        fkey(KEY_CLR);
        chk("ovf_clr_a", bus.operand_a, 0);
        chk("ovf_clr", bus.overflow, 0);

        give_result(16'h0055);
        chk("stray_res_state", bus.entry_state, 0);
        chk("stray_res_a", bus.operand_a, 0);

        // busy ALU
        bus.alu_busy = 1'b1;
        digit(4'd1);
        fkey(KEY_ADD);
        digit(4'd2);
        fkey(KEY_EQ);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_state", bus.entry_state, 2);
            chk("busy_start", bus.start, 0);
        end
        bus.alu_busy = 1'b0;
        tick();
        chk("busy_start_go", bus.start, 1);
        chk("busy_wait", bus.entry_state, 3);
        digit(4'd9);
        chk("wait_dig_ign", bus.operand_b, 32'h2);
        chk("wait_start_off", bus.start, 0);
        fkey(KEY_CLR);
        chk("wait_clr_ign", bus.entry_state, 3);
        give_result(16'h0042);
        chk("busy_res_state", bus.entry_state, 0);

        // 7 A C E
        fkey(KEY_CLR);
        digit(4'd7);
        fkey(KEY_ADD);
        fkey(KEY_MUL);
        fkey(KEY_EQ);
        chk("rep_op", bus.operator, 2);
        chk("rep_state", bus.entry_state, 1);
        chk("rep_disp", bus.display, 32'h7);

        // reset during WAIT
        digit(4'd3);
        fkey(KEY_EQ);
        tick();
        chk("rw_wait", bus.entry_state, 3);
        chk("rw_start", bus.start, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw_state", bus.entry_state, 0);
        chk("rw_start_drop", bus.start, 0);
        chk("rw_a", bus.operand_a, 0);
        chk("rw_b", bus.operand_b, 0);
        chk("rw_op", bus.operator, 0);
        give_result(16'h0099);
        chk("rw_res_state", bus.entry_state, 0);
        chk("rw_res_a", bus.operand_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
# operand_entry

Consumes decoded key events from the keypad scanner and assembles calculator input. Builds two BCD operands digit by digit and latches the operator from keys A–D. On `#` it issues a one-cycle start to the ALU, then waits for the result. Sits between the keypad scanner and the ALU/display path of the calc design.

## Interface
- `DIGITS`, default 4: maximum BCD digits per operand; must be ≥ 1.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; overrides every other input.
- `key_valid`  in  1  one-cycle strobe; `key`/`keytype` are meaningful only when high.
- `keytype`  in  1  1 = digit key (0–9), 0 = function key (A–F).
- `key`  in  4  key code: 0–9 digits, A/B/C/D = add/sub/mul/div, E = `#` (equals), F = `*` (clear).
- `alu_busy`  in  1  ALU is executing.
- `result_valid`  in  1  one-cycle strobe; `result` is valid when high.
- `result`  in  4*DIGITS  BCD result from the ALU.
- `operand_a`  out  4*DIGITS  BCD operand A; the least-significant digit occupies bits [3:0].
- `operand_b`  out  4*DIGITS  BCD operand B.
- `operator`  out  2  00 add, 01 sub, 10 mul, 11 div.
- `start`  out  1  one-cycle ALU launch pulse.
- `display`  out  4*DIGITS  operand currently shown.
- `overflow`  out  1  sticky: set when a digit is dropped because the operand is full.
- `entry_state`  out  2  FSM state: 00 ENTER_A, 01 ENTER_B, 10 ISSUE, 11 WAIT.

## Operation
- **States:** ENTER_A, ENTER_B, ISSUE, WAIT. Reset state is ENTER_A.
- **Digit key in ENTER_A or ENTER_B:** applies to the current operand.
  - If count < DIGITS: shift the operand left 4 bits, insert the key into [3:0], increment count.
  - Leading `0` when count = 0: operand stays 0 and count stays 0.
  - If count = DIGITS: digit is ignored and `overflow` is set.
- **Fresh A after a result:** a digit in ENTER_A while the `fresh` flag is set first zeroes operand A and count, then inserts the digit. The digit clears `fresh`.
- **Operator key (A–D):**
  - In ENTER_A: latch `operator`, zero operand B and its count, go to ENTER_B, clear `fresh`.
  - In ENTER_B with B count = 0: replaces `operator`.
  - In ENTER_B with B count > 0: ignored.
- **`#` key:**
  - In ENTER_B with B count > 0: go to ISSUE.
  - Anywhere else: ignored.
- **`*` key (clear):**
  - In ENTER_A, ENTER_B or ISSUE: zero both operands, both counts, `operator`, `overflow` and `fresh`; go to ENTER_A.
  - In WAIT: ignored.
- **ISSUE:** on an edge where `alu_busy` = 0, assert `start` for one cycle and go to WAIT. While `alu_busy` = 1, stay in ISSUE.
- **WAIT:**
  - All keys are ignored.
  - On `result_valid`: handle the result per Configuration, then go to ENTER_A.
- **Out-of-state inputs:** `result_valid` outside WAIT is ignored. `key_valid` in ISSUE is ignored, except `*`.
- **`display`:**
  - ENTER_A: `operand_a`.
  - ENTER_B: `operand_b` if B count > 0, else `operand_a`.
  - ISSUE and WAIT: `operand_b`.
- **Reset values:** all outputs are 0, `entry_state` = ENTER_A, both counts = 0, `fresh` = 0.

## Timing
- All outputs are registered.
- A key sampled at edge N is reflected on the outputs after edge N.
- **`#` to `start`:** `#` at edge N moves the FSM to ISSUE. If `alu_busy` = 0 at edge N+1, `start` is high for exactly the cycle after N+1. Minimum latency is 2 edges.
- **Result:** `result_valid` at edge M loads the operands. `entry_state` = ENTER_A after edge M.
- **Reset mid-operation:** reset in any state, including WAIT, returns to the reset values on that edge and drops a pending `start`.

## Configuration
- **`OPERAND_ENTRY_CHAIN_EN` defined:**
  - On `result_valid`, `operand_a` ← `result` and A count ← DIGITS.
  - `fresh` ← 1; operand B, its count and `operator` are zeroed.
  - An operator key then chains a new operation on the result.
- **Not defined:** `result_valid` zeroes all operands, counts and `operator`; `fresh` stays 0. The result is consumed only by downstream logic.

## Structure
- **Shared package `calc_pkg`:**
  - key-code constants (`KEY_ADD`…`KEY_CLR`, `KEY_EQ`);
  - operator encoding;
  - `entry_state` encoding;
  - digit-width constant (4).
- **Sub-module `bcd_shift_reg`:** instantiated twice, once per operand.
  - Owns the operand register and count.
  - Controls: insert, zero, load.
  - Provides the leading-zero rule and a `full` flag.

## Test plan
- **Basic add, DIGITS=4:** keys 1,2,A,3,E with `alu_busy`=0 → `operand_a`=0x0012, `operand_b`=0x0003, `operator`=00, `start` high one cycle, 2 edges after E.
- **Overflow and leading zeros:** keys 0,0,1,2,3,4,5 → `operand_a`=0x1234, `overflow`=1; key F → all zero, `overflow`=0.
- **Busy ALU:** E with `alu_busy`=1 for 5 cycles → `entry_state`=ISSUE throughout; `start` appears only in the cycle after the first edge with `alu_busy` low.
- **Operator replace and ignored keys:** keys 7,A,C,E → `operator`=10, `entry_state` stays ENTER_B because E is ignored at B count 0.
- **Chained result (macro defined):** `result_valid` with `result`=0x0099 in WAIT → `operand_a`=0x0099, ENTER_A. Then key B → ENTER_B with `operator`=01. Key 5 instead → `operand_a`=0x0005. Macro undefined → `operand_a`=0.
- **Reset during WAIT:** reset pulse → all outputs 0; a `result_valid` in the next cycle is ignored.
